reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised successor to the single-port-select register file for the pipelined RV32I core. It provides NRD simultaneous combinational read ports, one synchronous write port, and optional write-to-read bypass. An integrated scoreboard tracks pending writes per register, so decode can stall on RAW hazards without an external busy table. It sits between decode (reads, issue) and writeback (write, busy clear).

Parameters:
XLEN, 32, data width of each register in bits
NREGS, 32, number of architectural registers (2..64); AW = clog2(NREGS) is a derived localparam
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 is hardwired to zero, never written, never busy
BYPASS, 1, 1 = same-cycle writeback data forwarded to matching read ports

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
we  in  1  writeback write enable
wa  in  AW  writeback register address
wd  in  XLEN  writeback data
ra  in  NRD*AW  read addresses; port i = ra[i*AW +: AW]
rd  out  NRD*XLEN  read data; port i = rd[i*XLEN +: XLEN]
rd_rdy  out  NRD  port i operand is valid (not pending, or bypassed)
iss_valid  in  1  instruction issued that will write iss_rd
iss_rd  in  AW  destination register of the issuing instruction
flush  in  1  pipeline flush; discards all pending marks
busy  out  NREGS  scoreboard vector, bit r = write pending to register r

Behaviour:
- Reset (rst_n low, asynchronous): all registers := 0, all busy bits := 0. While in reset, rd reads all-zero and rd_rdy reads all-ones. Deassertion is synchronised externally; the block resumes on the first clk edge after release.
- Write: at posedge clk, if we && wa < NREGS && !(ZERO_REG && wa == 0), regs[wa] := wd. Otherwise no state change from the write port.
- Read (combinational, zero latency), per port i, first match wins:
  - ra_i >= NREGS: rd_i = 0.
  - ZERO_REG && ra_i == 0: rd_i = 0.
  - BYPASS && we && wa == ra_i (write legal): rd_i = wd.
  - Otherwise: rd_i = regs[ra_i], the pre-edge value.
- When BYPASS = 0, a read of a register being written in the same cycle returns the old value. The new value is visible the next cycle.
- Scoreboard update at posedge clk, in priority order:
  1. flush: all busy := 0. An iss_valid in the same cycle is ignored. A legal write still updates the register.
  2. iss_valid && legal iss_rd: busy[iss_rd] := 1.
  3. legal we: busy[wa] := 0, unless wa == iss_rd with iss_valid set that cycle. In that case set wins, because a new producer overrides the retiring one.
- Bits for illegal indices (reg 0 when ZERO_REG, or >= NREGS) are never set.
- rd_rdy_i is 1 if any of the following holds:
  - ra_i is reg 0 (ZERO_REG) or out of range;
  - busy[ra_i] == 0;
  - BYPASS && we && wa == ra_i.
  Otherwise rd_rdy_i is 0. It is computed from the current busy state, before this cycle's update.
- Multiple read ports may address the same register; each is evaluated independently with identical results.
- Out-of-order writebacks are allowed. A write to a non-busy register is legal and only updates data.
- Reset asserted mid-operation clears the data and all pending marks immediately, with no dependence on clk.

Test Plan:
- Reset then read ports 0..NRD-1 at x1,x2 -> rd = 0, rd_rdy = all-ones, busy = 0. Write x5 := 0xDEADBEEF, then read next cycle -> 0xDEADBEEF.
- Write x0 := 0xFFFFFFFF with ZERO_REG=1 -> read x0 = 0, busy[0] stays 0. With ZERO_REG=0, read x0 = 0xFFFFFFFF.
- Same-cycle write x7 := 0x12345678 while ra0 = x7:
  - BYPASS=1 -> rd0 = 0x12345678 that cycle, rd_rdy0 = 1.
  - BYPASS=0 -> rd0 = old value, then 0x12345678 the next cycle.
- Issue x3 -> busy[3] = 1 and rd_rdy = 0 on a port reading x3. Then write x3 := 0xA5 -> rd_rdy = 1 that cycle (BYPASS=1) and busy[3] = 0 the next cycle. Issue x3 and write x3 in the same cycle -> busy[3] stays 1.
- Issue x4, x9, then flush with iss_valid on x10 in the same cycle -> busy = 0 entirely, x10 not busy.
- Assert rst_n low asynchronously between edges with x5 busy and nonzero -> rd(x5) = 0 and busy = 0 immediately. NREGS=24 with wa = 30 write -> no change, read x30 = 0, rd_rdy = 1.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with NRD combinational read ports, one synchronous write port,
// optional write-to-read bypass and an integrated RAW scoreboard (busy bits).
module reg_file_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]    rd_rdy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              flush,
  output logic [NREGS-1:0]  busy
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             wr_ok, iss_ok;

  // An index is legal if it is in range and not the hardwired zero register.
  function automatic logic legal(input logic [AW-1:0] a);
    legal = (32'(a) < NREGS) && !(ZERO_REG && (a == '0));
  endfunction

  assign wr_ok  = we && legal(wa);
  assign iss_ok = iss_valid && legal(iss_rd);
  assign busy   = busy_q;

  // Register storage: synchronous write, asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else if (wr_ok) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (wa == AW'(r)) regs_q[r] <= wd;
      end
    end
  end

  // Scoreboard next state: flush beats everything; issue-set beats writeback-clear.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (wr_ok && (wa == AW'(r)))      busy_d[r] = 1'b0;
        if (iss_ok && (iss_rd == AW'(r))) busy_d[r] = 1'b1;
      end
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Read ports: range/zero check, then bypass, then array; ready from pre-edge busy.
  always_comb begin
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;
    logic            pend;
    rd     = '0;
    rd_rdy = '1;
    addr   = '0;
    val    = '0;
    pend   = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      addr = ra[i*AW +: AW];
      val  = '0;
      pend = 1'b0;
      if (legal(addr)) begin
        if (BYPASS && wr_ok && (wa == addr)) begin
          // Forwarded data is valid regardless of the pending mark.
          val = wd;
        end else begin
          for (int unsigned r = 0; r < NREGS; r++) begin
            if (addr == AW'(r)) begin
              val  = regs_q[r];
              pend = busy_q[r];
            end
          end
        end
      end
      // Held reset masks the bypass path so outputs read as cleared state.
      rd[i*XLEN +: XLEN] = rst_n ? val : '0;
      rd_rdy[i]          = !rst_n || !pend;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: three instances share stimulus to cover
// default config, BYPASS=0/ZERO_REG=0, and NREGS=24 (out-of-range indices).
module tb_reg_file_sb;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] wa;
  logic [31:0]   wd;
  logic [2*AW-1:0] ra;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          flush;

  logic [63:0] rd_a, rd_b, rd_c;
  logic [1:0]  rdy_a, rdy_b, rdy_c;
  logic [31:0] busy_a, busy_b;
  logic [23:0] busy_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a), .rd_rdy(rdy_a),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush), .busy(busy_a)
  );

  reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_b), .rd_rdy(rdy_b),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush), .busy(busy_b)
  );

  reg_file_sb #(.XLEN(32), .NREGS(24), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_c), .rd_rdy(rdy_c),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush), .busy(busy_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the directed sequence is a few dozen cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = {5'd2, 5'd1};
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
    #1;
    chk("reset_rd_a", rd_a, 64'h0);
    chk("reset_rdy_a", {62'h0, rdy_a}, 64'h3);
    chk("reset_busy_a", {32'h0, busy_a}, 64'h0);
    // Bypass must be masked while reset is held.
    we = 1'b1; wa = 5'd1; wd = 32'hFFFF_FFFF;
    #1;
    chk("reset_bypass_masked", rd_a, 64'h0);
    we = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();

    // Basic write then read.
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; ra = {5'd5, 5'd5};
    #1;
    chk("x5_read_a", rd_a, 64'hDEADBEEF_DEADBEEF);
    chk("x5_read_b", rd_b, 64'hDEADBEEF_DEADBEEF);
    chk("x5_read_c", rd_c, 64'hDEADBEEF_DEADBEEF);

    // Write/issue to x0: ignored on zero-reg config, real register on dut_b.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra = {5'd0, 5'd0};
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    chk("x0_bypass_a", rd_a[31:0], 64'h0);
    tick();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    chk("x0_read_a", rd_a[31:0], 64'h0);
    chk("x0_busy_a", {32'h0, busy_a}, 64'h0);
    chk("x0_read_b", rd_b[31:0], 64'hFFFF_FFFF);
    chk("x0_busy_b", {32'h0, busy_b}, 64'h1);
    chk("x0_rdy_b", {62'h0, rdy_b}, 64'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Same-cycle write x7 with read of x7.
    we = 1'b1; wa = 5'd7; wd = 32'h1234_5678; ra = {5'd0, 5'd7};
    #1;
    chk("x7_bypass_a", rd_a[31:0], 64'h1234_5678);
    chk("x7_rdy_a", {63'h0, rdy_a[0]}, 64'h1);
    chk("x7_old_b", rd_b[31:0], 64'h0);
    tick();
    we = 1'b0;
    #1;
    chk("x7_new_b", rd_b[31:0], 64'h1234_5678);

    // Issue x3, then writeback x3.
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    iss_valid = 1'b0; ra = {5'd0, 5'd3};
    #1;
    chk("x3_busy_a", {32'h0, busy_a}, 64'h8);
    chk("x3_notrdy_a", {63'h0, rdy_a[0]}, 64'h0);
    we = 1'b1; wa = 5'd3; wd = 32'h0000_00A5;
    #1;
    chk("x3_wb_rdy_a", {63'h0, rdy_a[0]}, 64'h1);
    chk("x3_wb_rd_a", rd_a[31:0], 64'hA5);
    chk("x3_wb_rdy_b", {63'h0, rdy_b[0]}, 64'h0);
    tick();
    we = 1'b0;
    #1;
    chk("x3_clear_a", {32'h0, busy_a}, 64'h0);
    chk("x3_read_a", rd_a[31:0], 64'hA5);

    // Issue and write the same register in one cycle: set wins.
    iss_valid = 1'b1; iss_rd = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'h77;
    tick();
    chk("x3_set_wins_1", {32'h0, busy_a}, 64'h8);
    tick();
    chk("x3_set_wins_2", {32'h0, busy_a}, 64'h8);
    iss_valid = 1'b0;
    tick();
    we = 1'b0;
    #1;
    chk("x3_final_clear", {32'h0, busy_a}, 64'h0);

    // Flush discards pending marks and a same-cycle issue; write still lands.
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    #1;
    chk("pending_4_9", {32'h0, busy_a}, 64'h210);
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd10; we = 1'b1; wa = 5'd11; wd = 32'hCAFE;
    tick();
    flush = 1'b0; iss_valid = 1'b0; we = 1'b0; ra = {5'd10, 5'd11};
    #1;
    chk("flush_busy_a", {32'h0, busy_a}, 64'h0);
    chk("flush_write_a", rd_a[31:0], 64'hCAFE);
    chk("flush_rdy_a", {62'h0, rdy_a}, 64'h3);

    // Asynchronous reset between edges.
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0; ra = {5'd0, 5'd5};
    #1;
    chk("pre_rst_busy", {32'h0, busy_a}, 64'h20);
    chk("pre_rst_rd", rd_a[31:0], 64'hDEAD_BEEF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd", rd_a[31:0], 64'h0);
    chk("async_rst_busy", {32'h0, busy_a}, 64'h0);
    chk("async_rst_rdy", {62'h0, rdy_a}, 64'h3);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_rd", rd_a[31:0], 64'h0);

    // Out-of-range write/issue on the 24-register instance.
    we = 1'b1; wa = 5'd30; wd = 32'hBAD; ra = {5'd23, 5'd30};
    iss_valid = 1'b1; iss_rd = 5'd30;
    #1;
    chk("oor_rd_c", rd_c[31:0], 64'h0);
    chk("oor_rdy_c", {62'h0, rdy_c}, 64'h3);
    tick();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    chk("oor_busy_c", {40'h0, busy_c}, 64'h0);
    chk("oor_read_c", rd_c, 64'h0);
    chk("inrange_x30_a", rd_a[31:0], 64'hBAD);
    chk("inrange_busy_a", {32'h0, busy_a}, 64'h4000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
